// File: rtl/pipe_reg_pkg.sv
// pipe_reg_pkg: defaults and legal parameter limits shared by pipe_reg and pipe_stage.
package pipe_reg_pkg;
  localparam int PIPE_REG_WIDTH_DEF = 16;
  localparam int PIPE_REG_DEPTH_DEF = 2;
  localparam int PIPE_REG_WIDTH_MIN = 1;
  localparam int PIPE_REG_WIDTH_MAX = 64;
  localparam int PIPE_REG_DEPTH_MIN = 1;
  localparam int PIPE_REG_DEPTH_MAX = 8;
endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one {vld, data} slot of pipe_reg; loads in_* when move is high.
// With PIPE_REG_CLR_DATA_EN defined, rst and flush also zero the data register.
module pipe_stage
  import pipe_reg_pkg::*;
#(
  parameter int WIDTH = PIPE_REG_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             move,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             vld,
  output logic [WIDTH-1:0] data
);
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] data_q, data_d;
  always_comb begin
    vld_d  = flush ? 1'b0 : (move ? in_vld : vld_q);
`ifdef PIPE_REG_CLR_DATA_EN
    data_d = flush ? '0 : ((move && in_vld) ? in_data : data_q);
`else
    data_d = (move && in_vld) ? in_data : data_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) vld_q <= 1'b0;
    else     vld_q <= vld_d;
  end
`ifdef PIPE_REG_CLR_DATA_EN
  always_ff @(posedge clk) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end
`else
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end
`endif
  assign vld  = vld_q;
  assign data = data_q;
endmodule

// File: rtl/pipe_reg.sv
// pipe_reg: DEPTH-stage valid/ready register pipeline that compresses bubbles when stalled.
// Optional PIPE_REG_CLR_DATA_EN zeroes data registers on rst/flush.
module pipe_reg
  import pipe_reg_pkg::*;
#(
  parameter int WIDTH = PIPE_REG_WIDTH_DEF,
  parameter int DEPTH = PIPE_REG_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_vld,
  output logic                       in_rdy,
  input  logic [WIDTH-1:0]           d,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic [WIDTH-1:0]           q,
  output logic [$clog2(DEPTH+1)-1:0] occ
);
  localparam int OW = $clog2(DEPTH+1);
  if (WIDTH < PIPE_REG_WIDTH_MIN || WIDTH > PIPE_REG_WIDTH_MAX ||
      DEPTH < PIPE_REG_DEPTH_MIN || DEPTH > PIPE_REG_DEPTH_MAX) begin : g_bad_param
    $error("pipe_reg: WIDTH or DEPTH out of range");
  end
  logic [DEPTH-1:0]            vld, move;
  logic [DEPTH-1:0][WIDTH-1:0] data;
  logic                        acc;
  // a stage moves if it is empty or everything downstream of it moves
  always_comb begin
    move[DEPTH-1] = !vld[DEPTH-1] || out_rdy;
    for (int k = DEPTH-2; k >= 0; k--) move[k] = !vld[k] || move[k+1];
    in_rdy = move[0] && !flush && !rst;
    occ = '0;
    for (int k = 0; k < DEPTH; k++) occ = occ + OW'(vld[k]);
  end
  assign acc = in_vld && in_rdy;
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             src_vld;
    logic [WIDTH-1:0] src_data;
    if (i == 0) begin : g_head
      assign src_vld  = acc;
      assign src_data = d;
    end else begin : g_body
      assign src_vld  = vld[i-1];
      assign src_data = data[i-1];
    end
    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk    (clk),
      .rst    (rst),
      .flush  (flush),
      .move   (move[i]),
      .in_vld (src_vld),
      .in_data(src_data),
      .vld    (vld[i]),
      .data   (data[i])
    );
  end
  assign out_vld = vld[DEPTH-1];
  assign q       = data[DEPTH-1];
endmodule

// File: tb/tb_pipe_reg.sv
// tb_pipe_reg: drives DEPTH=2 and DEPTH=3 pipes with shared stimulus, checks both against a slot model.
module tb_pipe_reg;
  logic             clk = 1'b0;
  logic             rst = 1'b0, flush = 1'b0, in_vld = 1'b0, out_rdy = 1'b0;
  logic [15:0]      d = '0;
  logic [1:0]       in_rdy_o, out_vld_o;
  logic [1:0][15:0] q_o;
  logic [1:0][1:0]  occ_o;
  int n_cmp = 0, n_err = 0;
  int slot[2][8];
  int dep[2] = '{2, 3};
  int last_q[2];
  bit armed = 0, beef_seen = 0;

  always #5 clk = ~clk;

  pipe_reg #(.WIDTH(16), .DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst), .flush(flush), .in_vld(in_vld), .in_rdy(in_rdy_o[0]), .d(d),
    .out_vld(out_vld_o[0]), .out_rdy(out_rdy), .q(q_o[0]), .occ(occ_o[0])
  );
  pipe_reg #(.WIDTH(16), .DEPTH(3)) u_d3 (
    .clk(clk), .rst(rst), .flush(flush), .in_vld(in_vld), .in_rdy(in_rdy_o[1]), .d(d),
    .out_vld(out_vld_o[1]), .out_rdy(out_rdy), .q(q_o[1]), .occ(occ_o[1])
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // highest stage that will shift this cycle; -1 means the pipe is stalled
  function automatic int shift_top(input int k, input bit rdy);
    int h = -1;
    if (rdy) return dep[k] - 1;
    for (int i = 0; i < dep[k]; i++) if (slot[k][i] < 0) h = i;
    return h;
  endfunction

  task automatic step(input bit r, input bit f, input bit v, input logic [15:0] dv, input bit o);
    rst = r; flush = f; in_vld = v; d = dv; out_rdy = o;
    #1;
    for (int k = 0; k < 2; k++) begin
      int h, cnt, tail;
      bit exp_rdy;
      h = shift_top(k, o);
      exp_rdy = !r && !f && h >= 0;
      cnt = 0;
      for (int i = 0; i < dep[k]; i++) cnt += (slot[k][i] >= 0) ? 1 : 0;
      tail = slot[k][dep[k]-1];
      if (armed) begin
        chk($sformatf("in_rdy_d%0d", dep[k]), int'(in_rdy_o[k]), int'(exp_rdy));
        chk($sformatf("out_vld_d%0d", dep[k]), int'(out_vld_o[k]), (tail >= 0) ? 1 : 0);
        chk($sformatf("occ_d%0d", dep[k]), int'(occ_o[k]), cnt);
        if (tail >= 0) chk($sformatf("q_d%0d", dep[k]), int'(q_o[k]), tail);
`ifdef PIPE_REG_CLR_DATA_EN
        else chk($sformatf("q_idle_d%0d", dep[k]), int'(q_o[k]), last_q[k]);
`endif
        if (out_vld_o[k] && q_o[k] == 16'hBEEF) beef_seen = 1;
      end
      if (r || f) begin
        for (int i = 0; i < 8; i++) slot[k][i] = -1;
        last_q[k] = 0;
      end else if (h >= 0) begin
        for (int i = h; i > 0; i--) slot[k][i] = slot[k][i-1];
        slot[k][0] = (v && exp_rdy) ? int'(dv) : -1;
        if (slot[k][dep[k]-1] >= 0) last_q[k] = slot[k][dep[k]-1];
      end
    end
    @(posedge clk);
    #1;
    if (r) armed = 1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) slot[k][i] = -1;
      last_q[k] = 0;
    end
    step(1, 0, 0, 16'h0, 1);
    step(1, 0, 1, 16'h1234, 1);
    for (int i = 1; i <= 5; i++) step(0, 0, 1, 16'(i), 1);
    repeat (4) step(0, 0, 0, 16'h0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 16'h0010 + 16'(i), 0);
    step(0, 0, 1, 16'h0013, 0);
    repeat (6) step(0, 0, 0, 16'h0, 1);
    repeat (3) step(0, 0, 1, 16'h0020, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 16'h0030 + 16'(i), 1);
    repeat (5) step(0, 0, 0, 16'h0, 1);
    step(0, 0, 1, 16'h0041, 0);
    step(0, 0, 1, 16'h0042, 0);
    beef_seen = 0;
    step(0, 1, 1, 16'hBEEF, 0);
    repeat (5) step(0, 0, 0, 16'h0, 1);
    chk("beef_absent", int'(beef_seen), 0);
    step(0, 0, 1, 16'h0051, 0);
    step(0, 0, 1, 16'h0052, 0);
    step(1, 0, 1, 16'h0053, 1);
    step(0, 0, 0, 16'h0, 1);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0,
           16'($urandom_range(0, 16'hBEEE)), $urandom_range(0, 1) == 1);
    repeat (4) step(0, 0, 0, 16'h0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
